// File: rtl/loader_pkg.sv
// Shared state encodings and constants for the UART program loader.
package loader_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_state_t;
  typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE} ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling timer and byte FSM.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_stop_err,
  output logic       o_frame_start
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic             r_rx_meta, r_rx_sync;
  byte_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_err, w_err_nxt;
  logic             r_start, w_start_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_start   <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_valid   <= w_valid_nxt;
      r_err     <= w_err_nxt;
      r_start   <= w_start_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_start_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_sync) w_state_nxt = START;
      end
      START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          if (r_rx_sync) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
            w_bit_nxt   = '0;
            w_start_nxt = 1'b1;
          end
        end
      end
      DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_sync, r_shift[7:1]};
          if (r_bit == LAST_BIT) w_state_nxt = STOP;
          else                   w_bit_nxt   = r_bit + 1'b1;
        end
      end
      STOP: begin
        // Return to IDLE straight after the mid-bit sample so a
        // back-to-back start edge is caught half a bit later.
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          if (r_rx_sync) w_valid_nxt = 1'b1;
          else           w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_byte_valid  = r_valid;
  assign o_byte_data   = r_shift;
  assign o_stop_err    = r_err;
  assign o_frame_start = r_start;

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a UART stream (32-bit LE word count, then that many LE words) into memory.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  logic        w_byte_valid, w_stop_err, w_frame_start;
  logic [7:0]  w_byte_data;
  logic [31:0] w_word;
  logic [ADDR_W:0] w_len_sat;

  ld_state_t       r_state, w_state_nxt;
  logic [1:0]      r_bidx, w_bidx_nxt;
  logic [23:0]     r_word, w_word_nxt;
  logic [ADDR_W:0] r_count, w_count_nxt;
  logic [ADDR_W:0] r_widx, w_widx_nxt;
  logic            r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]     r_wdata, w_wdata_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_ferr, w_ferr_nxt;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx         (rx),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte_data),
    .o_stop_err   (w_stop_err),
    .o_frame_start(w_frame_start)
  );

  assign w_word    = {w_byte_data, r_word};
  assign w_len_sat = (w_word > 32'(MAX_WORDS)) ? MAX_WORDS : w_word[ADDR_W:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= L_LEN;
      r_bidx  <= '0;
      r_word  <= '0;
      r_count <= '0;
      r_widx  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bidx  <= w_bidx_nxt;
      r_word  <= w_word_nxt;
      r_count <= w_count_nxt;
      r_widx  <= w_widx_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_busy  <= w_busy_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bidx_nxt  = r_bidx;
    w_word_nxt  = r_word;
    w_count_nxt = r_count;
    w_widx_nxt  = r_widx;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_busy_nxt  = r_busy;
    w_ferr_nxt  = r_ferr;
    if (r_state != L_DONE) begin
      if (w_frame_start) w_busy_nxt = 1'b1;
      // A bad stop bit abandons the partially assembled word.
      if (w_stop_err) begin
        w_ferr_nxt = 1'b1;
        w_bidx_nxt = '0;
      end else if (w_byte_valid) begin
        w_bidx_nxt = r_bidx + 2'd1;
        case (r_bidx)
          2'd0: w_word_nxt[7:0]   = w_byte_data;
          2'd1: w_word_nxt[15:8]  = w_byte_data;
          2'd2: w_word_nxt[23:16] = w_byte_data;
          default: begin
            if (r_state == L_LEN) begin
              w_count_nxt = w_len_sat;
              w_state_nxt = (w_len_sat == '0) ? L_DONE : L_DATA;
            end else begin
              w_we_nxt    = 1'b1;
              w_addr_nxt  = r_widx[ADDR_W-1:0];
              w_wdata_nxt = w_word;
              w_widx_nxt  = r_widx + 1'b1;
              if ((r_widx + 1'b1) == r_count) w_state_nxt = L_DONE;
            end
          end
        endcase
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign done      = (r_state == L_DONE);
  assign busy      = r_busy & ~done;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed + randomized bench for uart_prog_loader against a byte-stream reference model.
`timescale 1ns/1ps
module tb_uart_prog_loader;

  localparam int unsigned CPB  = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned NMAX = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy, done, frame_err;

  always #5 clk = ~clk;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .frame_err(frame_err)
  );

  int checks = 0;
  int errors = 0;

  // Observed writes: {done, addr, data}
  logic [36:0] got[$];
  logic [36:0] exp_q[$];
  logic [7:0]  byte_q[$];
  bit          bad_q[$];
  int          sent;
  bit          exp_done, exp_ferr, exp_busy;

  always @(negedge clk)
    if (!rst && mem_we) got.push_back({done, mem_addr, mem_wdata});

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bytes grouped into LE words; a bad stop byte restarts the group;
  // first word is the (saturated) count; everything after completion is ignored.
  task automatic run_model();
    logic [31:0] w;
    int idx, n, k;
    bit hdr;
    w = '0; idx = 0; n = 0; k = 0; hdr = 1'b1;
    exp_q.delete();
    exp_done = 1'b0;
    exp_ferr = 1'b0;
    foreach (byte_q[i]) begin
      if (exp_done) continue;
      if (bad_q[i]) begin exp_ferr = 1'b1; idx = 0; continue; end
      w = {byte_q[i], w[31:8]};
      idx++;
      if (idx == 4) begin
        idx = 0;
        if (hdr) begin
          hdr = 1'b0;
          n = (w > NMAX) ? NMAX : int'(w);
          if (n == 0) exp_done = 1'b1;
        end else begin
          exp_q.push_back({(k + 1 == n), 4'(k), w});
          k++;
          if (k == n) exp_done = 1'b1;
        end
      end
    end
    exp_busy = !exp_done && (byte_q.size() > 0);
  endtask

  task automatic drive(input bit v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    if (bad) begin
      drive(1'b0, 12);
      drive(1'b1, CPB + 4);
    end else begin
      drive(1'b1, CPB);
    end
  endtask

  task automatic add_byte(input logic [7:0] b, input bit bad);
    byte_q.push_back(b);
    bad_q.push_back(bad);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) add_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic send_pending(input int gapmax);
    int g;
    while (sent < byte_q.size()) begin
      send_byte(byte_q[sent], bad_q[sent]);
      sent++;
      g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      if (g > 0) drive(1'b1, g);
    end
  endtask

  task automatic do_reset();
    rx  = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    byte_q.delete();
    bad_q.delete();
    sent = 0;
  endtask

  task automatic compare(input string tag);
    drive(1'b1, 3 * CPB);
    run_model();
    check({tag, ".nwr"}, 64'(got.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got.size()) check($sformatf("%s.wr%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    check({tag, ".done"}, 64'(done), 64'(exp_done));
    check({tag, ".ferr"}, 64'(frame_err), 64'(exp_ferr));
    check({tag, ".busy"}, 64'(busy), 64'(exp_busy));
    check({tag, ".we_idle"}, 64'(mem_we), 64'(0));
    if (exp_q.size() > 0) begin
      check({tag, ".addr_hold"}, 64'(mem_addr), 64'(exp_q[exp_q.size()-1][35:32]));
      check({tag, ".data_hold"}, 64'(mem_wdata), 64'(exp_q[exp_q.size()-1][31:0]));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".we"},   64'(mem_we),    64'(0));
    check({tag, ".addr"}, 64'(mem_addr),  64'(0));
    check({tag, ".data"}, 64'(mem_wdata), 64'(0));
    check({tag, ".busy"}, 64'(busy),      64'(0));
    check({tag, ".done"}, 64'(done),      64'(0));
    check({tag, ".ferr"}, 64'(frame_err), 64'(0));
  endtask

  initial begin
    int n;
    rx  = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    check_zero("reset");

    // 1: single word
    add_word(32'd1);
    add_word(32'h12345678);
    send_pending(0);
    compare("t1");

    // 2: three words back-to-back
    do_reset();
    add_word(32'd3);
    for (int i = 0; i < 3; i++) add_word($urandom);
    send_pending(0);
    compare("t2");

    // 3: short glitch on idle line
    do_reset();
    drive(1'b0, 4);
    drive(1'b1, 3 * CPB);
    check("t3.nwr", 64'(got.size()), 64'(0));
    check("t3.busy", 64'(busy), 64'(0));
    check("t3.ferr", 64'(frame_err), 64'(0));
    check("t3.done", 64'(done), 64'(0));

    // 4: framing error on 2nd byte of first data word
    do_reset();
    add_word(32'd2);
    add_byte($urandom, 1'b0);
    add_byte($urandom, 1'b1);
    add_word($urandom);
    add_word($urandom);
    send_pending(0);
    compare("t4");

    // 5: zero-length header, later traffic ignored
    do_reset();
    add_word(32'd0);
    send_pending(0);
    compare("t5a");
    add_word($urandom);
    add_byte($urandom, 1'b1);
    send_pending(0);
    compare("t5b");

    // 6: reset mid-DATA of the 3rd byte, then a fresh stream
    do_reset();
    add_word(32'd2);
    sent = 0;
    for (int i = 0; i < 2; i++) begin
      send_byte(byte_q[i], 1'b0);
      sent++;
    end
    drive(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive(1'($urandom), CPB);
    drive(1'b0, CPB / 2);
    rx  = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("t6rst");
    rst = 1'b0;
    drive(1'b1, 12 * CPB);
    got.delete();
    byte_q.delete();
    bad_q.delete();
    sent = 0;
    add_word(32'd2);
    add_word($urandom);
    add_word($urandom);
    send_pending(0);
    compare("t6");

    // 7: count above memory size saturates
    do_reset();
    add_word(32'h0000_0100);
    for (int i = 0; i < 18; i++) add_word($urandom);
    send_pending(0);
    compare("t7");

    // 8: random lengths with random idle gaps
    for (int it = 0; it < 4; it++) begin
      do_reset();
      n = int'($urandom_range(1, 5));
      add_word(32'(n));
      for (int i = 0; i < n; i++) add_word($urandom);
      send_pending(20);
      compare($sformatf("t8_%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
